// File: rtl/control_pipe_if.sv
// Bundle of ID-stage decode inputs and staged control outputs of control_pipe.
// master drives the ID-stage inputs; slave is the pipeline itself.
interface control_pipe_if #(
    parameter int ALUOP_W = 3
);
    logic [6:0]         Op_i;
    logic               Funct7b0_i;
    logic               No_Op_i;
    logic               Flush_i;
    logic [ALUOP_W-1:0] ALUOp_ex_o;
    logic               ALUSrc_ex_o;
    logic               Branch_ex_o;
    logic               MulDiv_ex_o;
    logic               MemRead_mem_o;
    logic               MemWrite_mem_o;
    logic               RegWrite_wb_o;
    logic               MemtoReg_wb_o;
    logic               Busy_o;

    modport master (
        output Op_i, Funct7b0_i, No_Op_i, Flush_i,
        input  ALUOp_ex_o, ALUSrc_ex_o, Branch_ex_o, MulDiv_ex_o,
        input  MemRead_mem_o, MemWrite_mem_o, RegWrite_wb_o, MemtoReg_wb_o, Busy_o
    );

    modport slave (
        input  Op_i, Funct7b0_i, No_Op_i, Flush_i,
        output ALUOp_ex_o, ALUSrc_ex_o, Branch_ex_o, MulDiv_ex_o,
        output MemRead_mem_o, MemWrite_mem_o, RegWrite_wb_o, MemtoReg_wb_o, Busy_o
    );
endinterface

// File: rtl/control_pipe.sv
// Pipelined main control: decodes the ID opcode into a control bundle and carries it
// through ID/EX, EX/MEM and MEM/WB, holding EX while a multi-cycle MUL/DIV op runs.
module control_pipe #(
    parameter int ALUOP_W    = 3,
    parameter int EN_MULDIV  = 1,
    parameter int MUL_CYCLES = 4
) (
    input logic           clk_i,
    input logic           rst_i,
    control_pipe_if.slave bus
);
    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               branch;
        logic               mul_div;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
    } ctrl_t;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    ctrl_t      dec_s;
    ctrl_t      id_ex_nxt_s;
    ctrl_t      ex_mem_nxt_s;
    ctrl_t      id_ex_r;
    ctrl_t      ex_mem_r;
    ctrl_t      mem_wb_r;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       busy_s;
    logic       squash_s;

    // Busy comes straight from the counter register, never from the inputs.
    assign busy_s   = (EN_MULDIV != 0) && (cnt_r != 4'd0);
    assign squash_s = bus.Flush_i || bus.No_Op_i;

    // ID-stage opcode decode; unknown opcodes decode to a bubble.
    always_comb begin
        dec_s = '0;
        case (bus.Op_i)
            7'b0110011: begin
                dec_s.reg_write = 1'b1;
                dec_s.alu_op    = ALUOP_W'(3'b011);
                dec_s.mul_div   = (EN_MULDIV != 0) ? bus.Funct7b0_i : 1'b0;
            end
            7'b0010011: begin
                dec_s.reg_write = 1'b1;
                dec_s.alu_src   = 1'b1;
                dec_s.alu_op    = ALUOP_W'(3'b001);
            end
            7'b0000011: begin
                dec_s.reg_write  = 1'b1;
                dec_s.alu_src    = 1'b1;
                dec_s.mem_read   = 1'b1;
                dec_s.mem_to_reg = 1'b1;
                dec_s.alu_op     = ALUOP_W'(3'b000);
            end
            7'b0100011: begin
                dec_s.alu_src   = 1'b1;
                dec_s.mem_write = 1'b1;
                dec_s.alu_op    = ALUOP_W'(3'b000);
            end
            7'b1100011: begin
                dec_s.branch = 1'b1;
                dec_s.alu_op = ALUOP_W'(3'b110);
            end
            default: dec_s = '0;
        endcase
    end

    // Stage next-state: a running MUL/DIV holds ID/EX and feeds bubbles into EX/MEM.
    always_comb begin
        id_ex_nxt_s  = id_ex_r;
        ex_mem_nxt_s = id_ex_r;
        cnt_nxt_s    = cnt_r;
        if (busy_s) begin
            id_ex_nxt_s  = id_ex_r;
            ex_mem_nxt_s = '0;
        end else if (squash_s) begin
            id_ex_nxt_s  = '0;
            ex_mem_nxt_s = id_ex_r;
        end else begin
            id_ex_nxt_s  = dec_s;
            ex_mem_nxt_s = id_ex_r;
        end
        // Load takes precedence; it can only happen when the counter is already zero.
        if (!busy_s && !squash_s && dec_s.mul_div) begin
            cnt_nxt_s = CNT_LOAD;
        end else if (cnt_r != 4'd0) begin
            cnt_nxt_s = cnt_r - 4'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pipeline and occupancy-counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_ex_r  <= '0;
            ex_mem_r <= '0;
            mem_wb_r <= '0;
            cnt_r    <= 4'd0;
        end else begin
            id_ex_r  <= id_ex_nxt_s;
            ex_mem_r <= ex_mem_nxt_s;
            mem_wb_r <= ex_mem_r;
            cnt_r    <= cnt_nxt_s;
        end
    end

    assign bus.ALUOp_ex_o     = id_ex_r.alu_op;
    assign bus.ALUSrc_ex_o    = id_ex_r.alu_src;
    assign bus.Branch_ex_o    = id_ex_r.branch;
    assign bus.MulDiv_ex_o    = id_ex_r.mul_div;
    assign bus.MemRead_mem_o  = ex_mem_r.mem_read;
    assign bus.MemWrite_mem_o = ex_mem_r.mem_write;
    assign bus.RegWrite_wb_o  = mem_wb_r.reg_write;
    assign bus.MemtoReg_wb_o  = mem_wb_r.mem_to_reg;
    assign bus.Busy_o         = busy_s;
endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Parametrised, pipelined successor to the combinational main control decoder.
- Decodes the ID-stage opcode, with funct7[0] for M-extension detection, into a control bundle.
- Carries the bundle through ID/EX, EX/MEM and MEM/WB control registers.
- Inserts bubbles on hazard/flush requests and holds EX for multi-cycle MUL/DIV ops, raising a stall request to the hazard unit.

Parameters:
- ALUOP_W, 3, width of ALUOp bus (>=3); upper bits zero-filled.
- EN_MULDIV, 1, 1 enables MUL/DIV detection and multi-cycle hold; 0 treats funct7[0] as don't-care.
- MUL_CYCLES, 4, EX occupancy of a MUL/DIV op in cycles (1..16).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- Op_i  in  7  opcode of instruction in ID.
- Funct7b0_i  in  1  funct7[0] of instruction in ID.
- No_Op_i  in  1  hazard unit requests a bubble into ID/EX.
- Flush_i  in  1  branch flush; squash instruction in ID.
- ALUOp_ex_o  out  ALUOP_W  EX-stage ALU operation class.
- ALUSrc_ex_o  out  1  EX: 1 = immediate operand, 0 = rs2.
- Branch_ex_o  out  1  EX: branch instruction.
- MulDiv_ex_o  out  1  EX: multi-cycle MUL/DIV op.
- MemRead_mem_o  out  1  MEM-stage load.
- MemWrite_mem_o  out  1  MEM-stage store.
- RegWrite_wb_o  out  1  WB-stage register write.
- MemtoReg_wb_o  out  1  WB: 1 = load data, 0 = ALU result.
- Busy_o  out  1  stall request while MUL/DIV occupies EX.

Behaviour:
- Decode (combinational, ID):
  - R 0110011: RegWrite=1, ALUOp=011.
  - I 0010011: RegWrite=1, ALUSrc=1, ALUOp=001.
  - LW 0000011: RegWrite=1, ALUSrc=1, MemRead=1, MemtoReg=1, ALUOp=000.
  - SW 0100011: ALUSrc=1, MemWrite=1, ALUOp=000.
  - BEQ 1100011: Branch=1, ALUOp=110.
  - Any other opcode: all zero (bubble).
  - MulDiv=1 iff EN_MULDIV=1, opcode=0110011 and Funct7b0_i=1.
- Bubble = all control bits zero.
- Reset (async, immediate): all pipeline registers zero, counter zero, so every output is 0, including Busy_o.
- Busy_o = (cnt != 0); driven directly from the registered counter, no combinational path from inputs.
- ID/EX update, each rising edge, in priority order:
  1. Busy_o=1: hold.
  2. Flush_i or No_Op_i: load bubble.
  3. Otherwise: load the decoded bundle.
- EX/MEM: loads a bubble when Busy_o=1; otherwise loads the ID/EX contents.
- MEM/WB: always loads EX/MEM contents.
- Latency: instruction decoded in cycle N appears on EX outputs in N+1, MEM in N+2, WB in N+3, plus (MUL_CYCLES-1) for MUL/DIV ops.
- Counter (width 4):
  - On the edge where ID/EX loads an op with MulDiv=1: cnt <= MUL_CYCLES-1.
  - Else if cnt != 0: cnt decrements.
  - The op therefore sits in EX for MUL_CYCLES cycles, and Busy_o is high for MUL_CYCLES-1 of them.
  - Busy_o drops in the op's last EX cycle; on the following edge the op advances and ID/EX accepts a new instruction.
- MUL_CYCLES=1: counter never leaves 0, Busy_o never asserts, MulDiv ops flow like R-type.
- Back-to-back MulDiv: the second loads on the same edge the first leaves EX; the counter reloads MUL_CYCLES-1 with no idle cycle.
- Flush_i or No_Op_i while Busy_o=1: ignored (hold wins). The hazard unit must not drop a flush during Busy_o; the bench flags it as a protocol error.
- Reset mid-MUL: counter and all stages clear immediately; Busy_o=0 asynchronously.
- EN_MULDIV=0: MulDiv_ex_o constant 0, counter logic optimised away, Busy_o constant 0.

Test Plan:
- Reset: hold rst_i=1 with random Op_i -> all outputs 0. Release, then Op_i=0000011 at cycle 0 -> MemRead_mem_o=1 at cycle 2; RegWrite_wb_o=1 and MemtoReg_wb_o=1 at cycle 3.
- Decode sweep: present 0110011, 0010011, 0100011, 1100011, 1111111 on consecutive cycles -> EX sees ALUOp 011/001/000/110/000 with ALUSrc 0/1/1/0/0; MemWrite_mem_o=1 only for SW; 1111111 yields an all-zero bubble.
- Bubble and flush: LW at cycle 0 with No_Op_i=1 -> cycle 1 EX outputs all 0. Same with Flush_i=1 -> same result. Both low -> normal decode.
- MUL/DIV, MUL_CYCLES=4: R-type with Funct7b0_i=1 at cycle 0 -> MulDiv_ex_o=1 cycles 1-4; Busy_o=1 cycles 1-3; EX/MEM bubbles cycles 2-4; RegWrite_wb_o=1 at cycle 6. A second MUL presented at cycle 4 -> Busy_o=1 again in cycles 5-7.
- MUL_CYCLES=1 and EN_MULDIV=0 builds: the same MUL stimulus -> Busy_o never 1, RegWrite_wb_o=1 at cycle 3. With EN_MULDIV=0, MulDiv_ex_o also stays 0.
- Async reset mid-operation: assert rst_i between edges at cycle 2 of a MUL -> Busy_o and all outputs go 0 before the next edge. After release, the pipeline restarts clean with counter at 0.
